// File: rtl/biriscv_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, issues 64-bit ICache reads, drops
// stale responses after redirects and buffers packets for decode.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   branch_*_i               redirect strobe, target PC and privilege
//   icache_rd_o/pc_o/priv_o  read request (pc aligned to 8 bytes)
//   icache_accept_i          request taken this cycle
//   icache_valid_i/inst_i    in-order response data
//   icache_error_i           bus error on the response
//   icache_page_fault_i      page fault on the response
//   fetch_*_o                packet to decode (valid, instr, pc, flags)
//   fetch_accept_i           decode takes the packet
//   fetch_stall_cnt_o        stall counter (BIRISCV_FETCH_PERF_EN only)
module biriscv_fetch_seq #(
  parameter logic [31:0] BOOT_PC    = 32'h80000000,
  parameter int          RESP_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  input  logic [1:0]  branch_priv_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  output logic [1:0]  icache_priv_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic [1:0]  fetch_pred_branch_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
`ifdef BIRISCV_FETCH_PERF_EN
  output logic [31:0] fetch_stall_cnt_o,
`endif
  input  logic        fetch_accept_i
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int QW = PW + 1;
  localparam int SW = ((CNT_W > QW) ? CNT_W : QW) + 1;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [63:0] inst;
    logic [31:0] pc;
    logic        err;
    logic        pf;
  } resp_t;

  logic [31:0]      pc_q;
  logic [1:0]       priv_q;
  logic [CNT_W-1:0] out_q;
  logic [CNT_W-1:0] drop_q;

  logic [31:0]      tag_q [RESP_DEPTH];
  logic [PW-1:0]    tag_wr_q;
  logic [PW-1:0]    tag_rd_q;

  resp_t            buf_q [RESP_DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [QW-1:0]    count_q;

  logic [SW-1:0]    inflight;
  logic             issue;
  logic             push;
  logic             pop;
  logic             fault;
  resp_t            head;
  resp_t            wr_ent;

  // Outstanding plus buffered is capped so the FIFO can never overflow.
  always_comb begin
    inflight      = SW'(out_q) + SW'(count_q);
    icache_rd_o   = rst_ni && !branch_request_i
                    && (inflight < SW'(RESP_DEPTH));
    icache_pc_o   = {pc_q[31:3], 3'b0};
    icache_priv_o = priv_q;
    issue         = icache_rd_o && icache_accept_i;
    push          = icache_valid_i && !branch_request_i
                    && (drop_q == '0);
    fetch_valid_o = (count_q != '0);
    pop           = fetch_valid_o && fetch_accept_i;
    wr_ent.inst   = icache_inst_i;
    wr_ent.pc     = tag_q[tag_rd_q];
    wr_ent.err    = icache_error_i;
    wr_ent.pf     = icache_page_fault_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= BOOT_PC;
      priv_q <= 2'b11;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      if (branch_request_i) begin
        pc_q   <= branch_pc_i;
        priv_q <= branch_priv_i;
      end else if (issue) begin
        pc_q <= {pc_q[31:3] + 29'd1, 3'b0};
      end
      out_q <= out_q + CNT_W'(issue) - CNT_W'(icache_valid_i);
      // Everything still in flight after a redirect is stale.
      if (branch_request_i)
        drop_q <= out_q - CNT_W'(icache_valid_i);
      else if (icache_valid_i && drop_q != '0)
        drop_q <= drop_q - 1'b1;
    end
  end

  // Request PC tags; the first tag after a redirect keeps pc[2:0].
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RESP_DEPTH; i++)
        tag_q[i] <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else if (branch_request_i) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      if (issue) begin
        tag_q[tag_wr_q] <= pc_q;
        tag_wr_q        <= tag_wr_q + 1'b1;
      end
      if (push)
        tag_rd_q <= tag_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RESP_DEPTH; i++)
        buf_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (branch_request_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        buf_q[wr_q] <= wr_ent;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop)
        rd_q <= rd_q + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (!push && pop)
        count_q <= count_q - 1'b1;
    end
  end

  // A target with pc[2] set skips slot0 by turning it into a NOP.
  always_comb begin
    head                = buf_q[rd_q];
    fault               = head.err || head.pf;
    fetch_instr_o       = '0;
    fetch_pc_o          = '0;
    fetch_fault_fetch_o = 1'b0;
    fetch_fault_page_o  = 1'b0;
    fetch_pred_branch_o = 2'b00;
    if (fetch_valid_o) begin
      fetch_pc_o          = head.pc;
      fetch_fault_fetch_o = head.err;
      fetch_fault_page_o  = head.pf;
      if (!fault)
        fetch_instr_o = head.pc[2] ? {head.inst[63:32], NOP}
                                   : head.inst;
    end
  end

`ifdef BIRISCV_FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_q <= '0;
    else
      stall_q <= stall_q
                 + 32'(fetch_valid_o && !fetch_accept_i)
                 + 32'(icache_rd_o && !icache_accept_i);
  end

  assign fetch_stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_biriscv_fetch_seq.sv
// Testbench for biriscv_fetch_seq: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_biriscv_fetch_seq;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h80000000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        branch_request_i = 1'b0;
  logic [31:0] branch_pc_i = '0;
  logic [1:0]  branch_priv_i = '0;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic [1:0]  icache_priv_o;
  logic        icache_accept_i = 1'b0;
  logic        icache_valid_i = 1'b0;
  logic [63:0] icache_inst_i = '0;
  logic        icache_error_i = 1'b0;
  logic        icache_page_fault_i = 1'b0;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic        fetch_accept_i = 1'b0;
`ifdef BIRISCV_FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt_o;
`endif

  biriscv_fetch_seq #(
    .BOOT_PC(BOOT), .RESP_DEPTH(DEPTH), .CNT_W(2)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .branch_request_i(branch_request_i),
    .branch_pc_i(branch_pc_i),
    .branch_priv_i(branch_priv_i),
    .icache_rd_o(icache_rd_o),
    .icache_pc_o(icache_pc_o),
    .icache_priv_o(icache_priv_o),
    .icache_accept_i(icache_accept_i),
    .icache_valid_i(icache_valid_i),
    .icache_inst_i(icache_inst_i),
    .icache_error_i(icache_error_i),
    .icache_page_fault_i(icache_page_fault_i),
    .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o),
    .fetch_pc_o(fetch_pc_o),
    .fetch_pred_branch_o(fetch_pred_branch_o),
    .fetch_fault_fetch_o(fetch_fault_fetch_o),
    .fetch_fault_page_o(fetch_fault_page_o),
`ifdef BIRISCV_FETCH_PERF_EN
    .fetch_stall_cnt_o(fetch_stall_cnt_o),
`endif
    .fetch_accept_i(fetch_accept_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic        err;
    logic        pf;
    logic        stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic        err;
    logic        pf;
  } pkt_t;

  req_t        infl[$];
  pkt_t        outq[$];
  logic [31:0] m_pc;
  logic [1:0]  m_priv;
  logic [31:0] m_stall;

  logic [63:0] nx_data;
  logic        nx_err;
  logic        nx_pf;

  logic        o_rd;
  logic [31:0] o_pc;
  logic        o_fv;
  logic [31:0] o_fpc;
  logic [63:0] o_finstr;
  logic        o_fff;
  logic        o_ffp;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    branch_request_i = 1'b0;
    icache_accept_i = 1'b0;
    icache_valid_i = 1'b0;
    fetch_accept_i = 1'b0;
    #1;
    chk("rst_rd", icache_rd_o, 1'b0);
    chk("rst_pc", icache_pc_o, {BOOT[31:3], 3'b0});
    chk("rst_priv", icache_priv_o, 2'b11);
    chk("rst_fv", fetch_valid_o, 1'b0);
    chk("rst_instr", fetch_instr_o, 64'h0);
    chk("rst_fpc", fetch_pc_o, 32'h0);
    chk("rst_flags", {fetch_fault_fetch_o, fetch_fault_page_o,
                      fetch_pred_branch_o}, 4'h0);
    infl.delete();
    outq.delete();
    m_pc = BOOT;
    m_priv = 2'b11;
    m_stall = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock: drive inputs, check against the model, advance the model.
  task automatic cyc(input logic br, input logic [31:0] bpc,
                     input logic [1:0] bpriv, input logic acc,
                     input logic v, input logic fa);
    logic        e_rd;
    logic [63:0] e_in;
    pkt_t        h;
    req_t        r;
    if (infl.size() == 0) v = 1'b0;
    branch_request_i = br;
    branch_pc_i = bpc;
    branch_priv_i = bpriv;
    icache_accept_i = acc;
    fetch_accept_i = fa;
    icache_valid_i = v;
    if (v) begin
      icache_inst_i = infl[0].data;
      icache_error_i = infl[0].err;
      icache_page_fault_i = infl[0].pf;
    end else begin
      icache_inst_i = {$urandom, $urandom};
      icache_error_i = 1'b0;
      icache_page_fault_i = 1'b0;
    end
    #1;
    e_rd = !br && ((infl.size() + outq.size()) < DEPTH);
    chk("icache_rd", icache_rd_o, e_rd);
    chk("icache_pc", icache_pc_o, m_pc & ~32'h7);
    chk("icache_priv", icache_priv_o, m_priv);
    chk("fetch_valid", fetch_valid_o, outq.size() != 0);
    if (outq.size() != 0) begin
      h = outq[0];
      if (h.err || h.pf) e_in = 64'h0;
      else if (h.pc[2]) e_in = {h.data[63:32], 32'h00000013};
      else e_in = h.data;
      chk("fetch_pc", fetch_pc_o, h.pc);
      chk("fetch_instr", fetch_instr_o, e_in);
      chk("fault_fetch", fetch_fault_fetch_o, h.err);
      chk("fault_page", fetch_fault_page_o, h.pf);
      chk("pred_branch", fetch_pred_branch_o, 2'b00);
    end
    o_rd = icache_rd_o;
    o_pc = icache_pc_o;
    o_fv = fetch_valid_o;
    o_fpc = fetch_pc_o;
    o_finstr = fetch_instr_o;
    o_fff = fetch_fault_fetch_o;
    o_ffp = fetch_fault_page_o;

    if (outq.size() != 0 && !fa) m_stall++;
    if (e_rd && !acc) m_stall++;

    if (outq.size() != 0 && fa && !br) void'(outq.pop_front());
    if (v) begin
      r = infl.pop_front();
      if (!br && !r.stale)
        outq.push_back('{r.pc, r.data, r.err, r.pf});
    end
    if (br) begin
      outq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = bpc;
      m_priv = bpriv;
    end else if (e_rd && acc) begin
      infl.push_back('{m_pc, nx_data, nx_err, nx_pf, 1'b0});
      m_pc = (m_pc & ~32'h7) + 32'h8;
    end
    @(posedge clk_i);
    @(negedge clk_i);
`ifdef BIRISCV_FETCH_PERF_EN
    chk("stall_cnt", fetch_stall_cnt_o, m_stall);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (infl.size() == 0 && outq.size() == 0) break;
      cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b1);
    end
    chk("drain_timeout", infl.size() + outq.size(), 0);
  endtask

  localparam logic [63:0] D1 = 64'h00500093_00100093;
  localparam logic [63:0] D2 = 64'h00208133_00110113;
  localparam logic [63:0] D3 = 64'hAAAAAAAA_BBBBBBBB;

  initial begin
    int  nreq;
    logic found;
    nx_data = D1;
    nx_err = 1'b0;
    nx_pf = 1'b0;
    do_reset();

    // Boot fetch and single-cycle response.
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    nreq = int'(o_rd);
    chk("a_pc0", o_pc, 32'h80000000);
    nx_data = D2;
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    nreq += int'(o_rd);
    chk("a_pc1", o_pc, 32'h80000008);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    nreq += int'(o_rd);
    chk("a_fv", o_fv, 1'b1);
    chk("a_fpc", o_fpc, 32'h80000000);
    chk("a_data", o_finstr, D1);

    // Decode backpressure: request cap reached, head holds.
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 32'h0, 2'b00, 1'b1, i == 0, 1'b0);
      nreq += int'(o_rd);
      chk("b_hold_pc", o_fpc, 32'h80000000);
    end
    chk("b_nreq", nreq, 2);
    chk("b_rd_off", o_rd, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("b_pkt0", o_fpc, 32'h80000000);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("b_pkt1", o_fpc, 32'h80000008);
    chk("b_data1", o_finstr, D2);
    drain();

    // Redirect with two requests outstanding, misaligned target.
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h80001004, 2'b11, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("c_rd_blocked", o_rd, 1'b0);
    nx_data = D3;
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    chk("c_rd", o_rd, 1'b1);
    chk("c_pc", o_pc, 32'h80001000);
    chk("c_no_stale", o_fv, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("c_fv", o_fv, 1'b1);
    chk("c_fpc", o_fpc, 32'h80001004);
    chk("c_nop", o_finstr, {D3[63:32], 32'h00000013});
    drain();

    // Page fault on the response.
    nx_pf = 1'b1;
    nx_data = D1;
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    nx_pf = 1'b0;
    cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("d_fv", o_fv, 1'b1);
    chk("d_instr", o_finstr, 64'h0);
    chk("d_page", o_ffp, 1'b1);
    chk("d_fetch", o_fff, 1'b0);
    drain();

    // Redirect on a response cycle, then a second redirect.
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 32'h80002000, 2'b11, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h80003000, 2'b01, 1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
      if (o_fv) begin
        chk("e_first_pc", o_fpc, 32'h80003000);
        found = 1'b1;
        break;
      end
    end
    chk("e_seen", found, 1'b1);
    drain();

`ifdef BIRISCV_FETCH_PERF_EN
    // 5 decode stall cycles plus 3 ICache stall cycles.
    do_reset();
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("f_stall8", fetch_stall_cnt_o, 32'd8);
    drain();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      nx_data = {$urandom, $urandom};
      nx_err = ($urandom_range(0, 7) == 0);
      nx_pf = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 11) == 0, $urandom, 2'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/biriscv_fetch_seq.md
Name: biriscv_fetch_seq

Overview:
- Fetch sequencer directly upstream of the dual-issue decode stage.
- Owns the fetch PC and issues 64-bit aligned ICache read requests.
- Tracks outstanding requests, discards stale responses after a branch redirect, and buffers responses in a small FIFO.
- Presents one fetch packet per cycle (two 32-bit slots + PC + fault flags) with a valid/accept handshake to decode.

Parameters:
- BOOT_PC, 32'h80000000, fetch PC loaded at reset
- RESP_DEPTH, 2, response buffer entries; also the cap on (outstanding + buffered); power of 2, ≥2
- CNT_W, 2, width of the outstanding/drop counters; must hold RESP_DEPTH

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- branch_request_i  in  1  redirect strobe from execute/CSR
- branch_pc_i  in  32  redirect target
- branch_priv_i  in  2  privilege level for fetches after the redirect
- icache_rd_o  out  1  read request
- icache_pc_o  out  32  request address, bits [2:0] = 0
- icache_priv_o  out  2  request privilege
- icache_accept_i  in  1  request accepted this cycle
- icache_valid_i  in  1  response valid, in order, one per accepted request
- icache_inst_i  in  64  response data, slot0 = [31:0]
- icache_error_i  in  1  bus error on response
- icache_page_fault_i  in  1  page fault on response
- fetch_valid_o  out  1  packet valid
- fetch_instr_o  out  64  packet instructions
- fetch_pc_o  out  32  packet PC, bits [2:0] preserved
- fetch_pred_branch_o  out  2  bit0 = kill slot1, bit1 = reserved 0
- fetch_fault_fetch_o  out  1  bus error flag
- fetch_fault_page_o  out  1  page fault flag
- fetch_accept_i  in  1  decode accepts packet

Behaviour:
- Reset (rst_ni low, async):
  - pc_q = BOOT_PC, priv_q = 2'b11.
  - outstanding_q, drop_q, FIFO count and pointers = 0.
  - All outputs 0, except icache_pc_o = {BOOT_PC[31:3],3'b0} and icache_priv_o = 2'b11.
- Request:
  - icache_rd_o = rst_ni released && !branch_request_i && (outstanding_q + count_q) < RESP_DEPTH.
  - icache_pc_o = {pc_q[31:3],3'b0}.
  - On icache_rd_o & icache_accept_i: pc_q <= {pc_q[31:3]+1,3'b0}, outstanding++.
  - The PC of every accepted request is pushed into an RESP_DEPTH-entry PC tag queue. It pairs with the response and keeps the true pc_q[2:0] of the first request after a redirect.
- Response:
  - On icache_valid_i: outstanding--.
  - If drop_q != 0: drop_q-- and discard the response.
  - Otherwise push {inst, pc tag, error, page_fault} into the FIFO. The FIFO never overflows because of the request cap.
- Output:
  - FIFO head is registered; fetch_valid_o = count_q != 0.
  - Minimum latency: icache_valid_i in cycle N gives fetch_valid_o in cycle N+1.
  - Pop on fetch_valid_o & fetch_accept_i. Push and pop in the same cycle leave count unchanged.
  - While fetch_accept_i is low, head outputs hold stable.
- Misaligned target:
  - If the packet PC has bit2 = 1, slot0 is replaced by the NOP 32'h00000013.
  - fetch_pc_o keeps bit2 = 1.
- Faults:
  - If error or page_fault is set, fetch_instr_o = 64'b0 and the matching flag is set.
  - fetch_pred_branch_o = 2'b00 always (no predictor in this block).
- Redirect (branch_request_i = 1):
  - pc_q <= branch_pc_i, priv_q <= branch_priv_i.
  - Buffered FIFO entries and the PC tag queue are flushed.
  - drop_q <= outstanding count in flight after this cycle = outstanding_q − (icache_valid_i ? 1 : 0). No request is issued in the redirect cycle.
  - fetch_valid_o = 0 in the cycle after the redirect.
  - A response arriving in the redirect cycle is dropped.
  - Back-to-back redirects: drop_q is recomputed each time from the current outstanding count; the last target wins.
- Counters: outstanding_q never exceeds RESP_DEPTH; any underflow is a design error, and the bench asserts on it.

Optional Feature:
- Macro: BIRISCV_FETCH_PERF_EN.
- Defined: adds output fetch_stall_cnt_o [31:0].
  - Increments (wraps at 2^32) each cycle fetch_valid_o & !fetch_accept_i.
  - Also increments each cycle icache_rd_o & !icache_accept_i.
  - Cleared only by reset.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, icache_accept_i = 1, response 1 cycle later with data 64'h00500093_00100093 → icache_pc_o 0x80000000 then 0x80000008; fetch_valid_o with fetch_pc_o 0x80000000 and that data.
- fetch_accept_i = 0 for 10 cycles → exactly 2 requests issued, icache_rd_o = 0 afterwards, head stable; accept again → packets at 0x80000000 and 0x80000008 in order.
- Two requests outstanding, branch_request_i with target 0x80001004 → both stale responses discarded; next request 0x80001000; packet fetch_pc_o 0x80001004 with slot0 = 0x00000013.
- icache_page_fault_i = 1 on response → fetch_instr_o 0, fetch_fault_page_o 1, fetch_fault_fetch_o 0.
- Redirect coincident with a response arrival, then a second redirect 1 cycle later → no stale packet reaches the output; first packet is at the second target.
- BIRISCV_FETCH_PERF_EN: 5 cycles of decode backpressure plus 3 cycles of ICache backpressure → fetch_stall_cnt_o = 8.
